// File: rtl/uart_rx_byte_fifo.sv
// Receive-side byte FIFO between the UART receiver and the host; optional level/afull outputs under RX_FIFO_LEVEL_EN.
// Latency: one cycle from R_rdy to m_valid/m_data (show-ahead head, combinational read of registered storage).
// Backpressure: host stalls with m_ready=0; bytes arriving while full (and not popping) are dropped and flag overflow.
module uart_rx_byte_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              R_rdy,
    input  logic [DATA_W-1:0] data,
    input  logic              m_ready,
    input  logic              ovf_clr,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              full,
    output logic              empty,
`ifdef RX_FIFO_LEVEL_EN
    output logic [ADDR_W:0]   level,
    output logic              afull,
`endif
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              push;
    logic              pop;
    logic              drop;

    assign empty   = (count == '0);
    assign m_valid = ~empty;
    assign full    = (count == DEPTH_CNT);
    assign m_data  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop  = m_valid & m_ready;
    assign push = R_rdy & (~full | pop);
    assign drop = R_rdy & full & ~pop;

`ifdef RX_FIFO_LEVEL_EN
    assign level = count;
    assign afull = (count >= (ADDR_W+1)'(AFULL_THRESH));
`endif

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Directed plus randomized bench for uart_rx_byte_fifo against a queue-based reference model.
module tb_uart_rx_byte_fifo;

    logic       clk;
    logic       rst;
    logic       R_rdy;
    logic [7:0] data;
    logic       m_ready;
    logic       ovf_clr;
    logic       m_valid;
    logic [7:0] m_data;
    logic       full;
    logic       empty;
    logic       overflow;
`ifdef RX_FIFO_LEVEL_EN
    logic [4:0] level;
    logic       afull;
`endif

    uart_rx_byte_fifo #(
        .DATA_W(8), .DEPTH(16), .ADDR_W(4), .AFULL_THRESH(12)
    ) dut (
        .clk(clk), .rst(rst), .R_rdy(R_rdy), .data(data),
        .m_ready(m_ready), .ovf_clr(ovf_clr),
        .m_valid(m_valid), .m_data(m_data), .full(full), .empty(empty),
`ifdef RX_FIFO_LEVEL_EN
        .level(level), .afull(afull),
`endif
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] q [$];
    logic       ovf_m;
    int         max_cnt;
    logic [7:0] last_rd;
    logic [7:0] exp_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(m_valid), 32'(q.size() != 0));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".full"}, 32'(full), 32'(q.size() == 16));
        check({tag, ".ovf"}, 32'(overflow), 32'(ovf_m));
        if (q.size() != 0) check({tag, ".data"}, 32'(m_data), 32'(q[0]));
`ifdef RX_FIFO_LEVEL_EN
        check({tag, ".level"}, 32'(level), 32'(q.size()));
        check({tag, ".afull"}, 32'(afull), 32'(q.size() >= 12));
`endif
    endtask

    // One clock: drive inputs, advance the model with the FIFO rules, then compare.
    task automatic cyc(input string tag, input logic r, input logic [7:0] d,
                       input logic mr, input logic oc, input logic rs);
        logic pop_m, full_m;
        R_rdy = r; data = d; m_ready = mr; ovf_clr = oc; rst = rs;
        @(posedge clk);
        if (!rs) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            pop_m  = (q.size() != 0) && mr;
            full_m = (q.size() == 16);
            if (pop_m) begin
                last_rd = q[0];
                void'(q.pop_front());
            end
            if (r && (!full_m || pop_m)) q.push_back(d);
            if (r && full_m && !pop_m) ovf_m = 1'b1;
            else if (oc) ovf_m = 1'b0;
        end
        if (q.size() > max_cnt) max_cnt = q.size();
        #1;
        check_all(tag);
    endtask

    initial begin
        ovf_m = 1'b0;
        max_cnt = 0;
        last_rd = '0;
        cyc("rst0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc("rst1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("rst.valid", 32'(m_valid), 32'd0);
        check("rst.empty", 32'(empty), 32'd1);
        check("rst.ovf", 32'(overflow), 32'd0);

        // Single byte
        cyc("t1.push", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        check("t1.data", 32'(m_data), 32'h A5);
        cyc("t1.pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("t1.empty", 32'(empty), 32'd1);

        // Fill
        for (int i = 0; i < 16; i++) cyc("t2.fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        check("t2.full", 32'(full), 32'd1);

        // Overflow, drain order, clear, clear-vs-drop priority
        cyc("t3.drop", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        check("t3.ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("t3.order", 32'(m_data), 32'(i));
            cyc("t3.drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        cyc("t3.clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        check("t3.clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) cyc("t3.refill", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b1);
        cyc("t3.setwins", 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        check("t3.setwins", 32'(overflow), 32'd1);
        cyc("t3.clr2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Full with simultaneous push and pop
        cyc("t4.both", 1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
        check("t4.full", 32'(full), 32'd1);
        check("t4.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) cyc("t4.drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("t4.last", 32'(last_rd), 32'h55);

        // Streaming wrap with continuous read
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            exp_b = 8'($urandom);
            cyc("t5.stream", 1'b1, exp_b, 1'b1, 1'b0, 1'b1);
            check("t5.lat", 32'(m_data), 32'(exp_b));
        end
        check("t5.maxcnt", 32'(max_cnt), 32'd1);
        cyc("t5.tail", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Reset mid-stream with a coincident byte
        for (int i = 0; i < 5; i++) cyc("t6.buf", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b1);
        cyc("t6.rst", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        check("t6.empty", 32'(empty), 32'd1);
        cyc("t6.next", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        check("t6.first", 32'(m_data), 32'h3C);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rnd", 1'($urandom_range(0, 2) != 0), 8'($urandom),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 199) != 0));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
